// File: rtl/bit_count_pkg.sv
// -----------------------------------------------------------------------------
// bit_count_pkg
// Shared types and helpers for the bit_count_param block.
//   bc_state_t : controller state (IDLE, COUNT, DONE)
//   POP_MAX_W  : widest slice the popcount helper accepts
//   popcount() : number of set bits in a (zero-extended) slice
// -----------------------------------------------------------------------------
package bit_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } bc_state_t;

    localparam int unsigned POP_MAX_W = 64;

    // Callers zero-extend their STEP-bit slice to POP_MAX_W bits.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bit_count_datapath.sv
// -----------------------------------------------------------------------------
// bit_count_datapath
// Working shift register A plus the result accumulator.
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_load         : capture i_load_value into A and clear the result
//   i_enable       : one counting step (ignored once A is zero)
//   i_load_value   : operand already inverted for zero-count mode
//   o_a_zero       : A holds no set bits
//   o_result       : accumulated count
// -----------------------------------------------------------------------------
module bit_count_datapath
    import bit_count_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_a_zero,
    output logic [CNT_W-1:0] o_result
);

    logic [WIDTH-1:0] r_a;
    logic [CNT_W-1:0] r_result;
    logic [CNT_W-1:0] w_step_cnt;

    // Set bits in the low STEP bits of A, widened to the accumulator width.
    assign w_step_cnt = CNT_W'(popcount(POP_MAX_W'(r_a[STEP-1:0])));
    assign o_a_zero   = (r_a == '0);
    assign o_result   = r_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_result <= '0;
        end else if (i_load) begin
            r_a      <= i_load_value;
            r_result <= '0;
        end else if (i_enable && !o_a_zero) begin
            // Max total is WIDTH, which always fits in CNT_W bits.
            r_result <= r_result + w_step_cnt;
            r_a      <= r_a >> STEP;
        end
    end

endmodule

// File: rtl/bit_count_param.sv
// -----------------------------------------------------------------------------
// bit_count_param
// Counts the 1s (mode=0) or 0s (mode=1) of a WIDTH-bit word, STEP bits per
// clock, stopping early once no set bits remain in the working register.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : level request, sampled in IDLE and DONE
//   mode         : 0 = count ones, 1 = count zeros (sampled at load)
//   data         : operand (sampled at load)
//   result       : count, valid while done=1, held until the next load
//   busy         : high in COUNT
//   done         : high in DONE
//   o_dbg_state  : current controller state (bc_state_t encoding)
// Handshake: start is a level; a load happens on the first edge that sees
// start=1 in IDLE. done stays high until start is seen low, so one start
// level yields exactly one operation.
// Optional macro BIT_COUNT_SYNC_EN: start passes through a 2-flop
// synchroniser first, adding 2 cycles to every start-relative latency.
// -----------------------------------------------------------------------------
module bit_count_param
    import bit_count_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    generate
        if ((STEP == 0) || (WIDTH % STEP != 0) || (STEP > POP_MAX_W)) begin : g_bad_step
            $error("bit_count_param: STEP must be nonzero, divide WIDTH and not exceed POP_MAX_W");
        end
    endgenerate

    bc_state_t r_state;
    logic      w_start;
    logic      w_load;
    logic      w_enable;
    logic      w_a_zero;

`ifdef BIT_COUNT_SYNC_EN
    // start may come straight from a switch: two flops before the FSM.
    logic [1:0] r_start_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_sync <= 2'b00;
        end else begin
            r_start_sync <= {r_start_sync[0], start};
        end
    end

    assign w_start = r_start_sync[1];
`else
    assign w_start = start;
`endif

    assign w_load      = (r_state == IDLE) && w_start;
    assign w_enable    = (r_state == COUNT);
    assign busy        = (r_state == COUNT);
    assign done        = (r_state == DONE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start)  r_state <= COUNT;
                COUNT:   if (w_a_zero) r_state <= DONE;
                DONE:    if (!w_start) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    bit_count_datapath #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_enable     (w_enable),
        .i_load_value (mode ? ~data : data),
        .o_a_zero     (w_a_zero),
        .o_result     (result)
    );

endmodule

// File: tb/tb_bit_count_param.sv
// Bench for bit_count_param: an 8-bit/STEP=1 instance and a 16-bit/STEP=4
// instance, directed vectors, reset and hold sequences, random operations.
module tb_bit_count_param;

`ifdef BIT_COUNT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUTs ----------------
  logic       start8, mode8;
  logic [7:0] data8;
  logic [3:0] result8;
  logic       busy8, done8;
  logic [1:0] dbg8;

  logic        start16, mode16;
  logic [15:0] data16;
  logic [4:0]  result16;
  logic        busy16, done16;
  logic [1:0]  dbg16;

  bit_count_param #(.WIDTH(8), .STEP(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .mode(mode8), .data(data8),
    .result(result8), .busy(busy8), .done(done8), .o_dbg_state(dbg8)
  );

  bit_count_param #(.WIDTH(16), .STEP(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .mode(mode16), .data(data16),
    .result(result16), .busy(busy16), .done(done16), .o_dbg_state(dbg16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  int   cur = 0;
  logic busy_s, done_s;
  int   res_s;

  always_comb begin
    if (cur == 0) begin
      busy_s = busy8;
      done_s = done8;
      res_s  = int'(result8);
    end else begin
      busy_s = busy16;
      done_s = done16;
      res_s  = int'(result16);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_word(input int w, input logic [15:0] d, input logic m);
    logic [15:0] a;
    a = m ? ~d : d;
    for (int i = w; i < 16; i++) a[i] = 1'b0;
    return a;
  endfunction

  function automatic int model_count(input int w, input logic [15:0] d, input logic m);
    logic [15:0] a;
    int c;
    a = model_word(w, d, m);
    c = 0;
    for (int i = 0; i < 16; i++) if (a[i]) c++;
    return c;
  endfunction

  // Shift steps needed: ceil((p+1)/step) for highest set index p, 0 if none.
  function automatic int model_steps(input int w, input int step, input logic [15:0] d, input logic m);
    logic [15:0] a;
    int p;
    a = model_word(w, d, m);
    p = -1;
    for (int i = 0; i < 16; i++) if (a[i]) p = i;
    if (p < 0) return 0;
    return (p + step) / step;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int sel, input logic [15:0] d, input logic m, input logic s);
    if (sel == 0) begin
      data8 = d[7:0]; mode8 = m; start8 = s;
    end else begin
      data16 = d; mode16 = m; start16 = s;
    end
  endtask

  // Raise start and wait for done. lat counts edges from the start-sampling
  // edge (first edge) up to the one after which done is seen.
  task automatic run_op(input int sel, input logic [15:0] d, input logic m, input bit scramble,
                        output int res, output int busy_cnt, output int lat, output bit ok);
    cur = sel;
    drive(sel, d, m, 1'b1);
    busy_cnt = 0;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy_s) begin
        busy_cnt++;
        if (scramble) drive(sel, 16'($urandom), 1'($urandom), 1'b1);
      end
      if (done_s) begin
        ok = 1'b1;
        break;
      end
    end
    res = res_s;
    check("done reached", int'(ok), 1);
  endtask

  task automatic release_op(input int sel, input int held);
    cur = sel;
    if (sel == 0) start8 = 1'b0; else start16 = 1'b0;
    repeat (1 + SYNC_LAT) @(posedge clk);
    #1;
    check("done after release", int'(done_s), 0);
    check("busy after release", int'(busy_s), 0);
    check("result held", res_s, held);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          sel;
    logic [15:0] d;
    logic        m;
    int          exp_res;
    int          exp_busy;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int res, bcnt, lat;
    bit ok;
    int w, st, steps;
    logic [15:0] d;
    logic m;

    reset_n = 1'b0;
    drive(0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 1'b0, 1'b0);

    vecs[0] = '{0, 16'h00CA, 1'b0, 4,  9, 10};
    vecs[1] = '{0, 16'h009D, 1'b1, 3,  8,  9};
    vecs[2] = '{0, 16'h0000, 1'b0, 0,  1,  2};
    vecs[3] = '{0, 16'h00FF, 1'b1, 0,  1,  2};
    vecs[4] = '{1, 16'hFFFF, 1'b0, 16, 5,  6};
    vecs[5] = '{1, 16'h0001, 1'b0, 1,  2,  3};
    vecs[6] = '{0, 16'h0080, 1'b0, 1,  9, 10};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy8", int'(busy8), 0);
    check("reset done8", int'(done8), 0);
    check("reset result8", int'(result8), 0);
    check("reset busy16", int'(busy16), 0);
    check("reset done16", int'(done16), 0);
    check("reset result16", int'(result16), 0);
    check("reset state8", int'(dbg8), int'(bit_count_pkg::IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].d, vecs[i].m, 1'b0, res, bcnt, lat, ok);
      check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].exp_busy);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat + SYNC_LAT);
      release_op(vecs[i].sel, vecs[i].exp_res);
    end

    // start held through DONE: no second load even as data/mode change
    run_op(0, 16'h00CA, 1'b0, 1'b0, res, bcnt, lat, ok);
    check("hold first result", res, 4);
    for (int i = 0; i < 10; i++) begin
      drive(0, 16'($urandom), 1'($urandom), 1'b1);
      @(posedge clk); #1;
      check("hold done", int'(done8), 1);
      check("hold busy", int'(busy8), 0);
      check("hold result", int'(result8), 4);
    end
    release_op(0, 4);

    // asynchronous reset mid-COUNT
    cur = 0;
    drive(0, 16'h00CA, 1'b0, 1'b1);
    repeat (3 + SYNC_LAT) @(posedge clk);
    #1;
    check("busy before reset", int'(busy8), 1);
    check("partial result before reset", int'(result8), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy", int'(busy8), 0);
    check("async reset done", int'(done8), 0);
    check("async reset result", int'(result8), 0);
    drive(0, 16'h00CA, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle after reset busy", int'(busy8), 0);
      check("idle after reset done", int'(done8), 0);
    end
    // start already high when reset releases
    reset_n = 1'b0;
    drive(0, 16'h00CA, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (1 + SYNC_LAT) @(posedge clk);
    #1;
    check("load on first edge after release", int'(busy8), 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        ok = 1'b1;
        break;
      end
    end
    check("done after reset restart", int'(ok), 1);
    check("result after reset restart", int'(result8), 4);
    release_op(0, 4);

    // randomized operations against the model
    for (int sel = 0; sel < 2; sel++) begin
      w  = (sel == 0) ? 8 : 16;
      st = (sel == 0) ? 1 : 4;
      for (int k = 0; k < 30; k++) begin
        d = 16'($urandom);
        m = 1'($urandom);
        case ($urandom_range(0, 7))
          0: d = 16'h0000;
          1: d = 16'hFFFF;
          default: ;
        endcase
        exp_q.push_back(16'(model_count(w, d, m)));
        steps = model_steps(w, st, d, m);
        run_op(sel, d, m, 1'b1, res, bcnt, lat, ok);
        check($sformatf("rand w%0d result", w), res, int'(exp_q.pop_front()));
        check($sformatf("rand w%0d busy cycles", w), bcnt, steps + 1);
        check($sformatf("rand w%0d latency", w), lat, steps + 2 + SYNC_LAT);
        release_op(sel, res);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_count_param.md
# bit_count_param

Parametrised, multi-mode successor to the Lab 4 bit counter. On a `start` request it loads a WIDTH-bit word and counts either its 1s or its 0s. It examines STEP bits per clock and terminates early once no set bits remain in the working register. It sits between the board I/O (switch-driven `data`/`start`) and a seg7 display driver, exposing a `busy`/`done` handshake for a controlling FSM or LED.

## Interface
Parameters:
- WIDTH, 8, input word width (≥1).
- STEP, 1, bits examined per cycle. It must divide WIDTH; elaboration fails otherwise.
- CNT_W, $clog2(WIDTH+1), result width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level request. Sampled only in IDLE and DONE.
- mode  input  1  0 = count ones, 1 = count zeros. Sampled at load only.
- data  input  WIDTH  operand. Sampled at load only.
- result  output  CNT_W  count. Valid while done=1 and held until the next load.
- busy  output  1  high in COUNT.
- done  output  1  high in DONE.

## Operation
- Three states: IDLE, COUNT, DONE. busy and done are decoded directly from the state register.
- IDLE:
  - When start=1 at an edge, load `A <= mode ? ~data : data` and `result <= 0`, then go to COUNT.
  - Otherwise stay in IDLE and hold `result`.
- COUNT, evaluated each edge:
  - If A==0, go to DONE; A and result are unchanged.
  - Else `result <= result + popcount(A[STEP-1:0])` and `A <= A >> STEP` (zero fill); stay in COUNT.
- DONE:
  - If start=0, go to IDLE.
  - Else stay in DONE, so one start level produces exactly one operation.
- Arithmetic: the accumulator is CNT_W bits and never overflows, because the maximum count is WIDTH. The per-step popcount is zero-extended to CNT_W.
- start deasserting during COUNT does not abort. The operation completes, DONE lasts one cycle, then the block returns to IDLE.
- data and mode changes after the load edge have no effect on the current operation.
- Reset (any time, including mid-COUNT): state=IDLE, A=0, result=0, busy=0, done=0, immediately and asynchronously.

## Timing
- Let p be the index of the highest 1 in the loaded A.
- Number of shift steps: N = ceil((p+1)/STEP), with N=0 when A=0.
- Load edge L. COUNT occupies edges L+1 through L+N+1. done rises after edge L+N+1.
- Worst case: WIDTH/STEP + 2 cycles from the start-sampling edge to done.
- Best case: data all-zero in mode 0, or all-ones in mode 1. done rises 2 edges after start is sampled.
- done stays high for at least 1 cycle. It falls one edge after start is seen low in DONE.
- busy is high for exactly N+1 cycles per operation.

## Configuration
- Macro: BIT_COUNT_SYNC_EN.
- Defined:
  - start passes through an internal 2-flop synchroniser, reset to 0 by reset_n, before reaching the FSM.
  - All start-relative latencies above grow by 2 cycles.
  - start may come straight from a switch.
- Undefined: start is used directly and must already be synchronous to clk.

## Structure
- Package bit_count_pkg holds:
  - the state enum typedef `bc_state_t` {IDLE, COUNT, DONE};
  - a `popcount` function for STEP-bit slices.
- Sub-module bit_count_datapath (A shift register plus result accumulator). It is driven by load/enable controls from the FSM in bit_count_param and reports `a_zero` back to it.

## Test plan
- WIDTH=8, STEP=1, mode=0, data=8'b11001010, start held → busy for 9 cycles, then done=1 with result=4; start low → IDLE next edge, result stays 4.
- Same configuration, mode=1, data=8'b10011101 → result=3 (zero count). A=~data=8'b01100010 (p=6), so busy lasts 8 cycles.
- WIDTH=8, data=8'h00, mode=0 → done 2 edges after start is sampled, result=0, busy for 1 cycle. Same timing for data=8'hFF with mode=1, result=0.
- WIDTH=16, STEP=4, data=16'hFFFF, mode=0 → result=16 (CNT_W=5), busy for 5 cycles.
- Assert reset_n=0 mid-COUNT → busy, done and result go to 0 without waiting for a clock edge. After release, no operation starts while start=0. With start already held high at release, a new load occurs on the first edge after release.
- Hold start high through DONE for 10 cycles → done stays 1 and no second load occurs. With BIT_COUNT_SYNC_EN defined, re-run the first scenario → done rises 2 cycles later.
